// File: rtl/entrada_pkg.sv
// rtl/entrada_pkg.sv - shared types and constants for the switch input peripheral
package entrada_pkg;

  localparam int DATA_W = 32;

  // endereco[0] selects how the captured switches are widened
  localparam logic EXT_ZERO  = 1'b0;
  localparam logic EXT_SINAL = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ESPERA  = 2'd1,
    LIBERA  = 2'd2,
    ENTREGA = 2'd3
  } estado_t;

endpackage

// File: rtl/debounce_botao.sv
// rtl/debounce_botao.sv - synchronizer and debouncer for the active-low confirm button
module debounce_botao #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic nivel,
  output logic subida,
  output logic descida
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          raw_s1_q, raw_s2_q;
  logic          nivel_q, nivel_d;
  logic          subida_q, descida_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_sync;
  logic          vira;

  assign btn_sync = ~raw_s2_q;

  // Any sample that agrees with the accepted level restarts the stability run
  always_comb begin
    cnt_d = '0;
    vira  = 1'b0;
    if (btn_sync != nivel_q) begin
      if (cnt_q == CNT_MAX) begin
        vira = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign nivel_d = nivel_q ^ vira;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      raw_s1_q  <= 1'b1;
      raw_s2_q  <= 1'b1;
      nivel_q   <= 1'b0;
      cnt_q     <= '0;
      subida_q  <= 1'b0;
      descida_q <= 1'b0;
    end else begin
      raw_s1_q  <= raw;
      raw_s2_q  <= raw_s1_q;
      nivel_q   <= nivel_d;
      cnt_q     <= cnt_d;
      subida_q  <= vira & ~nivel_q;
      descida_q <= vira & nivel_q;
    end
  end

  assign nivel   = nivel_q;
  assign subida  = subida_q;
  assign descida = descida_q;

endmodule

// File: rtl/entrada_de_dados.sv
// rtl/entrada_de_dados.sv - IN-instruction peripheral: stalls the CPU until a switch value is confirmed
module entrada_de_dados
  import entrada_pkg::*;
#(
  parameter int NUM_SW          = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              IN,
  input  logic [DATA_W-1:0] endereco,
  input  logic [NUM_SW-1:0] SW,
  input  logic              KEY,
  output logic [DATA_W-1:0] dado_de_entrada,
  output logic              pausa,
  output logic              pronto
);

  localparam int PAD = DATA_W - NUM_SW;

  estado_t           estado_q, estado_d;
  logic [NUM_SW-1:0] sw_s1_q, sw_s2_q;
  logic [NUM_SW-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] dado_q, dado_d;
  logic [DATA_W-1:0] estendido;
  logic              subida, descida;
  logic              nivel_unused;
  logic              endereco_unused;

  assign endereco_unused = ^endereco[DATA_W-1:1];

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_botao (
    .clock  (clock),
    .reset  (reset),
    .raw    (KEY),
    .nivel  (nivel_unused),
    .subida (subida),
    .descida(descida)
  );

  always_comb begin
    estendido = {{PAD{1'b0}}, cap_q};
    case (endereco[0])
      EXT_ZERO:  estendido = {{PAD{1'b0}}, cap_q};
      EXT_SINAL: estendido = {{PAD{cap_q[NUM_SW-1]}}, cap_q};
      default:   estendido = {{PAD{1'b0}}, cap_q};
    endcase
  end

  // Only an edge seen while waiting counts, so a button already held on entry is ignored
  always_comb begin
    estado_d = estado_q;
    cap_d    = cap_q;
    dado_d   = dado_q;
    pronto   = 1'b0;
    unique case (estado_q)
      IDLE: begin
        if (IN) estado_d = ESPERA;
      end
      ESPERA: begin
        if (!IN) begin
          estado_d = IDLE;
        end else if (subida) begin
          cap_d    = sw_s2_q;
          estado_d = LIBERA;
        end
      end
      LIBERA: begin
        if (!IN) begin
          estado_d = IDLE;
        end else if (descida) begin
          estado_d = ENTREGA;
        end
      end
      ENTREGA: begin
        pronto   = 1'b1;
        dado_d   = estendido;
        estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      cap_q    <= '0;
      dado_q   <= '0;
    end else begin
      estado_q <= estado_d;
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
      cap_q    <= cap_d;
      dado_q   <= dado_d;
    end
  end

  // The CPU writes back in the ENTREGA cycle itself, so bypass the output register then
  assign pausa           = IN && (estado_q != ENTREGA);
  assign dado_de_entrada = (estado_q == ENTREGA) ? estendido : dado_q;

endmodule

// File: doc/entrada_de_dados.md
Name: entrada_de_dados

Overview:
Memory-mapped input peripheral, the read-side counterpart to the display output block. When the CPU executes an IN instruction, this block stalls the CPU until the user sets the switches and presses and releases a confirm button. It then returns the switch value, zero- or sign-extended to 32 bits. It sits beside the datapath: the data feeds the register-file write mux, and `pausa` feeds the PC/stall control.

Parameters:
NUM_SW, 16, number of switch inputs used (1..31)
DEBOUNCE_CYCLES, 500000, consecutive stable samples required before a button level change is accepted (>=2)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
IN  input  1  CPU input-request flag, held high while the IN instruction is stalled
endereco  input  32  input address; bit0 selects the extension mode (0 = zero-extend, 1 = sign-extend); bits 31:1 are ignored
SW  input  NUM_SW  raw switch levels, asynchronous to clock
KEY  input  1  raw confirm button, active-low, bouncy, asynchronous
dado_de_entrada  output  32  captured, extended switch value
pausa  output  1  stall request to the CPU
pronto  output  1  one-cycle strobe when the data is delivered

Behaviour:
- Reset: clock-domain reset is asynchronous, active-high.
  - All registers clear: state=IDLE, dado_de_entrada=0, pronto=0.
  - Debounced button = released.
  - Debounce counter = 0. Synchronizer flops are set to 0 (SW) and 1 (KEY).
- Synchronization: SW and KEY each pass through a 2-flop synchronizer. The button is inverted after synchronization (btn = ~KEY_sync).
- Debounce:
  - Counter increments while btn_sync != btn_db, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, btn_db flips and the counter clears.
  - Press-to-detect latency = 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- FSM states: IDLE, ESPERA (wait for press), LIBERA (wait for release), ENTREGA (deliver).
  - IDLE: IN=1 -> ESPERA.
  - ESPERA: a btn_db rising edge (debounced press) captures the synchronized SW into the capture register and moves to LIBERA. If btn_db is already 1 on entry, no capture occurs; a fresh press is required.
  - LIBERA: a btn_db falling edge -> ENTREGA.
  - ENTREGA: pronto=1 for exactly this cycle, then -> IDLE.
  - IN=0 in ESPERA or LIBERA -> IDLE (request cancelled, e.g. by a flush). The capture register is not changed.
- Output extension:
  - dado_de_entrada is registered and updates in ENTREGA using endereco[0] sampled in that cycle.
  - Zero-extend: {0, SW}.
  - Sign-extend: replicate SW[NUM_SW-1] into bits 31:NUM_SW.
  - The value holds until the next ENTREGA.
- pausa (combinational): IN && (state != ENTREGA). It is therefore high from the first IN cycle through LIBERA, and low in the ENTREGA cycle so the CPU advances and writes dado_de_entrada. To make the value valid in that same cycle, the extended value is computed from the capture register and driven combinationally during ENTREGA. After ENTREGA it is held in the register.
- Back-to-back IN: IN is still high in the cycle after ENTREGA -> IDLE -> ESPERA, and a new press/release is required.
- Switch changes after the press is captured have no effect on the delivered value.
- Reset mid-operation: immediate return to IDLE with pausa=0 (IN is low under CPU reset). The pending value is lost.

Decomposition:
- Package entrada_pkg: FSM state typedef (IDLE=2'd0, ESPERA=2'd1, LIBERA=2'd2, ENTREGA=2'd3), DATA_W=32 constant, and extension-mode constants (EXT_ZERO=0, EXT_SINAL=1).
- Sub-module debounce_botao: contains the synchronizer and the counter. Parameter DEBOUNCE_CYCLES; ports clock, reset, raw (active-low), nivel (debounced, active-high), subida and descida (one-cycle edge pulses).

Test Plan (DEBOUNCE_CYCLES=4, NUM_SW=16):
- Reset -> dado_de_entrada=0, pausa=0, pronto=0. Raise IN with no press -> pausa stays 1 for 100 cycles and the state remains ESPERA.
- Normal read: IN=1, endereco=0, SW=16'h8005, then press KEY clean for 10 cycles and release -> pronto pulses once. In the pronto cycle dado_de_entrada=32'h00008005 and pausa=0.
- Sign-extend: same sequence with endereco=1 and SW=16'h8005 -> dado_de_entrada=32'hFFFF8005. With SW=16'h7FFF -> 32'h00007FFF.
- Bounce: KEY toggled every 2 cycles for 20 cycles, then held low for 10 cycles -> exactly one capture; no pronto until the clean release is debounced.
- SW changed from 16'h0001 to 16'h0002 while in LIBERA -> delivered value is 32'h00000001.
- Cancel and reset: IN dropped in LIBERA -> IDLE, no pronto, dado unchanged. Reset asserted in ESPERA -> IDLE, and a later press with IN=0 produces no pronto.
